// File: rtl/cacheline_burst_adapter.sv
// cacheline_burst_adapter
//   Splits a cache line read / write-back into a burst of BEATS bus beats
//   (LINE_W/BUS_W) and reassembles read beats into a full line.
//
// Ports
//   clk, rst          : clock, synchronous active-low reset
//   pmem_read/write   : line read / write-back request (sampled in IDLE only)
//   pmem_address      : line address (low log2(LINE_W/8) bits dropped)
//   pmem_wdata        : line to write back
//   pmem_rdata        : assembled read line, held until the next read beat
//   pmem_resp         : one-cycle completion pulse
//   pmem_err          : completion ended by beat timeout
//   bus_read/write    : burst strobes, high for the whole burst
//   bus_address       : line-aligned burst address
//   bus_wdata         : current write beat
//   bus_rdata         : current read beat
//   bus_resp          : beat accepted / valid this cycle
//
// Build option
//   CACHELINE_ADAPTER_TIMEOUT_EN : abort a beat after TIMEOUT_CYC cycles
//   without bus_resp and complete with pmem_err=1. Undefined by default:
//   pmem_err is tied low and the adapter waits indefinitely.

module cacheline_burst_adapter #(
    parameter int LINE_W      = 256,
    parameter int BUS_W       = 64,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [ADDR_W-1:0] pmem_address,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              pmem_err,
    output logic              bus_read,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_address,
    output logic [BUS_W-1:0]  bus_wdata,
    input  logic [BUS_W-1:0]  bus_rdata,
    input  logic              bus_resp
);

    localparam int BEATS = LINE_W / BUS_W;
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_W / 8 - 1);
    localparam logic [KW-1:0]     LAST_BEAT  = KW'(BEATS - 1);

    if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0 || LINE_W != BEATS * BUS_W
        || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("cacheline_burst_adapter: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t            state, state_nx;
    logic [KW-1:0]     k;
    logic [LINE_W-1:0] wline;
    logic              in_burst;
    logic              last_beat;
    logic              timeout_hit;

    assign in_burst  = (state == READ) || (state == WRITE);
    assign last_beat = bus_resp && (k == LAST_BEAT);

`ifdef CACHELINE_ADAPTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] wcnt;
    logic          err_q;

    // Counts consecutive beat-less cycles; IDLE clears it so each burst starts fresh.
    always_ff @(posedge clk) begin
        if (!rst || !in_burst || bus_resp) begin
            wcnt <= '0;
        end else begin
            wcnt <= wcnt + 1'b1;
        end
    end

    // The TIMEOUT_CYC-th consecutive idle cycle ends the burst.
    assign timeout_hit = in_burst && !bus_resp && (wcnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (state == IDLE) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign pmem_err = (state == RESP) && err_q;
`else
    assign timeout_hit = 1'b0;
    assign pmem_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (pmem_read) begin
                    state_nx = READ;
                end else if (pmem_write) begin
                    state_nx = WRITE;
                end
            end
            READ, WRITE: begin
                if (last_beat || timeout_hit) begin
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            k           <= '0;
            bus_address <= '0;
            wline       <= '0;
            pmem_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pmem_read || pmem_write) begin
                        bus_address <= pmem_address & ALIGN_MASK;
                        k           <= '0;
                        // Read wins a simultaneous request; the write line is not captured.
                        if (!pmem_read) begin
                            wline <= pmem_wdata;
                        end
                    end
                end
                READ: begin
                    if (bus_resp) begin
                        pmem_rdata[k*BUS_W +: BUS_W] <= bus_rdata;
                        k <= last_beat ? '0 : k + 1'b1;
                    end
                end
                WRITE: begin
                    if (bus_resp) begin
                        k <= last_beat ? '0 : k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_read  = (state == READ);
    assign bus_write = (state == WRITE);
    assign pmem_resp = (state == RESP);
    assign bus_wdata = (state == WRITE) ? wline[k*BUS_W +: BUS_W] : '0;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// tb_cacheline_burst_adapter
//   Drives directed and randomized cache line transactions into
//   cacheline_burst_adapter, plays the memory bus side, and compares every
//   observable output against a line-level reference kept in the bench.

module tb_cacheline_burst_adapter;

    localparam int LINE_W = 256;
    localparam int BUS_W  = 64;
    localparam int ADDR_W = 32;
    localparam int BEATS  = LINE_W / BUS_W;
    localparam int TO_CYC = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              pmem_read, pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp, pmem_err;
    logic              bus_read, bus_write;
    logic [ADDR_W-1:0] bus_address;
    logic [BUS_W-1:0]  bus_wdata;
    logic [BUS_W-1:0]  bus_rdata;
    logic              bus_resp;

    int n_checks = 0;
    int n_fail   = 0;
    logic [LINE_W-1:0] exp_rdata;

    cacheline_burst_adapter #(
        .LINE_W     (LINE_W),
        .BUS_W      (BUS_W),
        .ADDR_W     (ADDR_W),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp),
        .pmem_err    (pmem_err),
        .bus_read    (bus_read),
        .bus_write   (bus_write),
        .bus_address (bus_address),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .bus_resp    (bus_resp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // mode 0: beat every cycle, 1: alternate cycles starting idle, 2: random
    function automatic logic pick_resp(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 2) == 1;
            default: return (c > 40) ? 1'b1 : 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run_read(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] line,
                            input int mode, input bit with_write);
        int   beat;
        logic r;
        pmem_read    = 1'b1;
        pmem_write   = with_write;
        pmem_address = addr;
        pmem_wdata   = rand_line();
        tick();
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = $urandom;
        pmem_wdata   = rand_line();
        chk("rd_addr", LINE_W'(bus_address), LINE_W'(addr & ~32'h1F));
        beat = 0;
        for (int c = 0; beat < BEATS; c++) begin
            chk("rd_strobes", LINE_W'({bus_read, bus_write, pmem_resp, pmem_err}), LINE_W'(4'b1000));
            r         = pick_resp(mode, c);
            bus_resp  = r;
            bus_rdata = r ? line[beat*BUS_W +: BUS_W] : {$urandom, $urandom};
            tick();
            if (r) begin
                exp_rdata[beat*BUS_W +: BUS_W] = line[beat*BUS_W +: BUS_W];
                beat++;
            end
        end
        bus_resp  = 1'($urandom_range(0, 1));
        bus_rdata = {$urandom, $urandom};
        chk("rd_resp", LINE_W'({pmem_resp, pmem_err, bus_read, bus_write}), LINE_W'(4'b1000));
        chk("rd_data", pmem_rdata, exp_rdata);
        chk("rd_line", pmem_rdata, line);
        tick();
        bus_resp = 1'b0;
        chk("rd_resp_once", LINE_W'({pmem_resp, bus_read, bus_write}), '0);
    endtask

    task automatic run_write(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] line,
                             input int mode);
        int   beat;
        int   resp_seen;
        logic r;
        pmem_write   = 1'b1;
        pmem_address = addr;
        pmem_wdata   = line;
        tick();
        pmem_write   = 1'b0;
        pmem_address = $urandom;
        pmem_wdata   = rand_line();
        chk("wr_addr", LINE_W'(bus_address), LINE_W'(addr & ~32'h1F));
        beat = 0;
        for (int c = 0; beat < BEATS; c++) begin
            chk("wr_strobes", LINE_W'({bus_read, bus_write, pmem_resp, pmem_err}), LINE_W'(4'b0100));
            chk("wr_beat", LINE_W'(bus_wdata), LINE_W'(line[beat*BUS_W +: BUS_W]));
            r         = pick_resp(mode, c);
            bus_resp  = r;
            bus_rdata = {$urandom, $urandom};
            tick();
            if (r) beat++;
        end
        bus_resp = 1'($urandom_range(0, 1));
        chk("wr_resp", LINE_W'({pmem_resp, pmem_err, bus_read, bus_write}), LINE_W'(4'b1000));
        chk("wr_rdata_hold", pmem_rdata, exp_rdata);
        resp_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus_resp = 1'b0;
            if (pmem_resp) resp_seen++;
        end
        chk("wr_resp_count", LINE_W'(resp_seen), '0);
    endtask

    initial begin
        logic [LINE_W-1:0] line;
        logic [ADDR_W-1:0] addr;

        rst          = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        bus_rdata    = '0;
        bus_resp     = 1'b0;
        exp_rdata    = '0;
        tick();
        tick();
        chk("rst_ctrl", LINE_W'({pmem_resp, pmem_err, bus_read, bus_write}), '0);
        chk("rst_addr", LINE_W'(bus_address), '0);
        chk("rst_wdata", LINE_W'(bus_wdata), '0);
        chk("rst_rdata", pmem_rdata, '0);
        rst = 1'b1;

        // bus_resp while idle does nothing
        bus_resp = 1'b1;
        tick();
        tick();
        chk("idle_ignore", LINE_W'({pmem_resp, bus_read, bus_write}), '0);
        bus_resp = 1'b0;

        // Directed read: four constant beats, beat every cycle
        line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        run_read(32'h0000_1234, line, 0, 1'b0);
        chk("rd_dir_addr", LINE_W'(bus_address), LINE_W'(32'h0000_1220));

        // Directed write with beats on alternate cycles
        run_write(32'h0000_ABCD, rand_line(), 1);

        // Simultaneous read+write: read executes, then a re-issued write works
        line = rand_line();
        run_read(32'h1234_5678, line, 2, 1'b1);
        run_write(32'h1234_5678, rand_line(), 2);

        // Reset after two beats of a read
        line         = rand_line();
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_4000;
        tick();
        pmem_read = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus_resp  = 1'b1;
            bus_rdata = line[b*BUS_W +: BUS_W];
            tick();
        end
        rst = 1'b0;
        tick();
        exp_rdata = '0;
        chk("rst_mid_ctrl", LINE_W'({pmem_resp, bus_read, bus_write}), '0);
        chk("rst_mid_rdata", pmem_rdata, exp_rdata);
        rst      = 1'b1;
        bus_resp = 1'b1;
        tick();
        chk("rst_mid_after", LINE_W'({pmem_resp, bus_read, bus_write}), '0);
        bus_resp = 1'b0;
        run_read(32'h0000_4000, rand_line(), 0, 1'b0);

        // Beat withheld after the first beat
        line         = rand_line();
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_8040;
        tick();
        pmem_read = 1'b0;
        bus_resp  = 1'b1;
        bus_rdata = line[BUS_W-1:0];
        tick();
        exp_rdata[BUS_W-1:0] = line[BUS_W-1:0];
        bus_resp = 1'b0;
`ifdef CACHELINE_ADAPTER_TIMEOUT_EN
        for (int i = 0; i < TO_CYC; i++) begin
            chk("to_wait", LINE_W'({pmem_resp, pmem_err, bus_read}), LINE_W'(3'b001));
            tick();
        end
        chk("to_resp", LINE_W'({pmem_resp, pmem_err, bus_read, bus_write}), LINE_W'(4'b1100));
        chk("to_rdata", pmem_rdata, exp_rdata);
        tick();
        chk("to_after", LINE_W'({pmem_resp, pmem_err, bus_read}), '0);
`else
        for (int i = 0; i < 3 * TO_CYC; i++) begin
            chk("no_to_wait", LINE_W'({pmem_resp, pmem_err, bus_read}), LINE_W'(3'b001));
            tick();
        end
        rst = 1'b0;
        tick();
        rst       = 1'b1;
        exp_rdata = '0;
        chk("no_to_abort", LINE_W'({pmem_resp, pmem_err, bus_read}), '0);
`endif

        // Randomized mix
        for (int t = 0; t < 8; t++) begin
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) run_read(addr, rand_line(), int'($urandom_range(0, 2)), 1'b0);
            else                           run_write(addr, rand_line(), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cacheline_burst_adapter.md
CACHELINE_BURST_ADAPTER -- requirements
Module: cacheline_burst_adapter

Interface
REQ-001 The block SHALL have parameter LINE_W, default 256, meaning cache line width in bits.
REQ-002 The block SHALL have parameter BUS_W, default 64, meaning memory bus beat width in bits; LINE_W SHALL be a power-of-two multiple of BUS_W, with BEATS = LINE_W/BUS_W and BEATS >= 2.
REQ-003 The block SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 1024, meaning the maximum number of wait cycles per beat; it is used only under the configuration macro.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port pmem_read, input, 1 bit: cache line read request.
REQ-008 The block SHALL have port pmem_write, input, 1 bit: cache line write-back request.
REQ-009 The block SHALL have port pmem_address, input, ADDR_W bits: line address.
REQ-010 The block SHALL have port pmem_wdata, input, LINE_W bits: line to write.
REQ-011 The block SHALL have port pmem_rdata, output, LINE_W bits: assembled line.
REQ-012 The block SHALL have port pmem_resp, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port pmem_err, output, 1 bit: completion with timeout error.
REQ-014 The block SHALL have port bus_read, output, 1 bit: burst read strobe.
REQ-015 The block SHALL have port bus_write, output, 1 bit: burst write strobe.
REQ-016 The block SHALL have port bus_address, output, ADDR_W bits: line-aligned burst address.
REQ-017 The block SHALL have port bus_wdata, output, BUS_W bits: current write beat.
REQ-018 The block SHALL have port bus_rdata, input, BUS_W bits: current read beat.
REQ-019 The block SHALL have port bus_resp, input, 1 bit: beat accepted/valid this cycle.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, READ, WRITE and RESP.
REQ-021 In IDLE, a sampled pmem_read SHALL go to READ and a sampled pmem_write SHALL go to WRITE; if both are high, READ SHALL win and the write is not latched.
REQ-022 On leaving IDLE, the block SHALL latch the address with its low log2(LINE_W/8) bits zeroed into bus_address, SHALL latch pmem_wdata (on write only), and SHALL clear the beat counter.
REQ-023 In READ, bus_read SHALL be 1 constantly; each cycle with bus_resp=1 SHALL store bus_rdata into line bits [(k+1)*BUS_W-1 : k*BUS_W] for beat k and then increment k.
REQ-024 In WRITE, bus_write SHALL be 1 and bus_wdata SHALL be latched-line slice k; k SHALL advance on bus_resp.
REQ-025 After the beat with k = BEATS-1 is accepted, the FSM SHALL go to RESP; the counter SHALL wrap to 0 and SHALL never exceed BEATS-1.
REQ-026 In RESP, pmem_resp SHALL be 1 for exactly one cycle, bus strobes SHALL be 0, and the next state SHALL be IDLE.
REQ-027 pmem_rdata SHALL be valid in the RESP cycle and SHALL hold until the next read's first beat.
REQ-028 Latency SHALL be: from request sample, pmem_resp rises 1 cycle after the final bus_resp; the minimum is BEATS+2 cycles.
REQ-029 Changes or deassertion of pmem_read, pmem_write, pmem_address or pmem_wdata outside IDLE SHALL be ignored; the burst always completes.
REQ-030 The requester SHALL drop its request in the cycle after pmem_resp; a request still high in IDLE SHALL start a new transaction.
REQ-031 bus_resp in IDLE or RESP SHALL be ignored.

Reset
REQ-032 When rst=0 at a clock edge, the block SHALL set the FSM to IDLE, k=0, and pmem_resp, pmem_err, bus_read, bus_write, bus_address, bus_wdata and pmem_rdata to 0.
REQ-033 A reset mid-burst SHALL abort the burst with no pmem_resp, and the strobes SHALL drop in the next cycle.

Configuration
REQ-034 With CACHELINE_ADAPTER_TIMEOUT_EN defined, a wait counter SHALL clear on each beat and on entry to READ/WRITE, and SHALL increment on cycles without bus_resp; reaching TIMEOUT_CYC SHALL drop the strobes and go to RESP with pmem_resp=1 and pmem_err=1, leaving pmem_rdata partially updated.
REQ-035 Without CACHELINE_ADAPTER_TIMEOUT_EN, no wait counter SHALL exist, pmem_err SHALL be constant 0, and the block SHALL wait indefinitely for bus_resp.

Verification
REQ-036 Read at 0x0000_1234 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 and bus_resp every cycle -> bus_address=0x0000_1220, pmem_resp at cycle 6, pmem_rdata={44..,33..,22..,11..}.
REQ-037 Write of line {D3,D2,D1,D0} with bus_resp on alternate cycles -> bus_wdata sequence D0,D1,D2,D3, and exactly one pmem_resp.
REQ-038 pmem_read and pmem_write high simultaneously -> READ executes, bus_write is never asserted, and a write re-issued afterwards executes normally.
REQ-039 rst=0 after beat 2 of a read -> strobes are 0 the next cycle, there is no pmem_resp, and a following read completes correctly.
REQ-040 With the macro and TIMEOUT_CYC=8, bus_resp is withheld after beat 1 -> pmem_resp=pmem_err=1 after 8 idle cycles; without the macro there is no resp and pmem_err=0.
